// File: rtl/eq_cmp_pkg.sv
// Shared definitions for the equality-comparator stimulus generator.
//   state_t     : sweep FSM states
//   CMP_W       : default operand width of the comparator under test
//   MAX_LATENCY : largest supported response latency (sizes the drain counter)
package eq_cmp_pkg;

  localparam int CMP_W       = 4;
  localparam int MAX_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/eq_cmp_exp_delay.sv
// Expected-response delay line. Each driven vector enters as
// {valid, exp, a, b} and leaves LATENCY cycles later, so it lines up with
// the comparator's answer for that vector. LATENCY=0 is a pure wire.
// Ports:
//   clk, rst_n             : clock, synchronous active-low clear of all stages
//   in_valid/in_exp/in_a/in_b     : entry for the vector presented this cycle
//   out_valid/out_exp/out_a/out_b : entry whose response is due this cycle
module eq_cmp_exp_delay #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_exp,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_exp,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  localparam int EW = 2 + 2 * WIDTH;

  logic [EW-1:0] in_e;
  logic [EW-1:0] out_e;

  assign in_e = {in_valid, in_exp, in_a, in_b};
  assign {out_valid, out_exp, out_a, out_b} = out_e;

  generate
    if (LATENCY == 0) begin : g_pass
      // Combinational comparator: no storage, clock and clear are unused.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n};
      assign out_e = in_e;
    end else begin : g_pipe
      logic [EW-1:0] stage [LATENCY];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= in_e;
          for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign out_e = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/eq_cmp_stim_gen.sv
// Self-test driver/checker for an equality comparator (Y = A==B).
// On an accepted start it drives every {A,B} pair, one per cycle, and
// compares the returned y_in against A==B, allowing LATENCY cycles of
// response delay. It reports a saturating error count and the first
// failing pair.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request a sweep; only looked at in IDLE, so it is a
//                     level/pulse request with no ready handshake -- a start
//                     seen while busy or in DONE is simply dropped
//   y_in            : comparator result
//   a_out, b_out    : operands to the comparator (registered)
//   busy            : high in DRIVE and DRAIN
//   done            : one-cycle completion pulse
//   pass            : sweep finished with zero errors; held until next start
//   err_count       : mismatches in current/last sweep, saturating
//   fail_valid      : at least one mismatch recorded
//   first_fail_a/b  : operands of the first mismatch
module eq_cmp_stim_gen
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH   = CMP_W,
  parameter int LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               y_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = VW + 1;
  localparam int DW = $clog2(MAX_LATENCY + 1);
  localparam logic [DW-1:0] DRAIN_LAST = (LATENCY > 0) ? DW'(LATENCY - 1) : '0;

  state_t          state;
  logic [VW-1:0]   idx;
  logic [DW-1:0]   drain_cnt;

  logic             q_valid;
  logic             q_exp;
  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic             mismatch;
  logic [EW-1:0]    err_next;

  // The index register is the driven vector; it holds the last pair
  // through DRAIN and DONE.
  assign a_out = idx[VW-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];

  eq_cmp_exp_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_exp_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state == DRIVE),
    .in_exp    (a_out == b_out),
    .in_a      (a_out),
    .in_b      (b_out),
    .out_valid (q_valid),
    .out_exp   (q_exp),
    .out_a     (q_a),
    .out_b     (q_b)
  );

  assign mismatch = q_valid && (y_in != q_exp);

  // Error count including this cycle's check; also used to decide pass on
  // the edge that enters DONE, so the final check is never missed.
  always_comb begin
    err_next = err_count;
    if (mismatch && !(&err_count)) err_next = err_count + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_valid   <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else begin
      done <= 1'b0;

      if (state == DRIVE || state == DRAIN) begin
        err_count <= err_next;
        if (mismatch && !fail_valid) begin
          fail_valid   <= 1'b1;
          first_fail_a <= q_a;
          first_fail_b <= q_b;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= DRIVE;
            idx          <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
          end
        end

        DRIVE: begin
          if (idx == '1) begin
            if (LATENCY == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            idx <= idx + VW'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_cmp_stim_gen.sv
// Bench for eq_cmp_stim_gen: one instance at LATENCY=0 and one at LATENCY=2,
// each fed by a small comparator model whose behaviour is selected per sweep.
// Expected sweep results come from a pair-by-pair reference computation.
module tb_eq_cmp_stim_gen;

  // response modes of the comparator model
  localparam int M_IDEAL   = 0;  // y = a==b of the current cycle
  localparam int M_STUCK0  = 1;
  localparam int M_STUCK1  = 2;
  localparam int M_DELAYED = 3;  // y = a==b of two cycles ago

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n = 1'b0, rst2_n = 1'b0;
  logic       start0 = 1'b0, start2 = 1'b0;
  logic       y0, y2;
  logic [3:0] a0, b0, a2, b2, ffa0, ffb0, ffa2, ffb2;
  logic       busy0, done0, pass0, fv0, busy2, done2, pass2, fv2;
  logic [8:0] err0, err2;
  int         mode0 = M_IDEAL, mode2 = M_IDEAL;
  logic       h1 = 1'b0, h2 = 1'b0;

  eq_cmp_stim_gen #(.WIDTH(4), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .y_in(y0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  eq_cmp_stim_gen #(.WIDTH(4), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .y_in(y2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail_a(ffa2), .first_fail_b(ffb2)
  );

  // comparator models
  always_comb begin
    case (mode0)
      M_STUCK0: y0 = 1'b0;
      M_STUCK1: y0 = 1'b1;
      default:  y0 = (a0 == b0);
    endcase
  end

  always @(posedge clk) begin
    h1 <= (a2 == b2);
    h2 <= h1;
  end

  always_comb begin
    case (mode2)
      M_STUCK0:  y2 = 1'b0;
      M_STUCK1:  y2 = 1'b1;
      M_DELAYED: y2 = h2;
      default:   y2 = (a2 == b2);
    endcase
  end

  // observation mux for whichever instance a test is driving
  bit         sel = 1'b0;
  logic       obs_busy, obs_done, obs_pass, obs_fv;
  logic [3:0] obs_a, obs_b, obs_ffa, obs_ffb;
  logic [8:0] obs_err;
  always_comb begin
    obs_busy = sel ? busy2 : busy0;
    obs_done = sel ? done2 : done0;
    obs_pass = sel ? pass2 : pass0;
    obs_fv   = sel ? fv2   : fv0;
    obs_a    = sel ? a2    : a0;
    obs_b    = sel ? b2    : b0;
    obs_ffa  = sel ? ffa2  : ffa0;
    obs_ffb  = sel ? ffb2  : ffb0;
    obs_err  = sel ? err2  : err0;
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // For every pair k, the answer checked against it is the comparator's
  // response to the pair on the bus LATENCY cycles later (the bus holds the
  // last pair after the sweep), or a fixed level for the stuck models.
  function automatic void ref_sweep(input int mode, input int lat, output int errs,
                                    output bit fv, output int fa, output int fb);
    int r;
    bit y, e;
    errs = 0; fv = 1'b0; fa = 0; fb = 0;
    for (int k = 0; k < 256; k++) begin
      e = ((k / 16) == (k % 16));
      case (mode)
        M_STUCK0:  y = 1'b0;
        M_STUCK1:  y = 1'b1;
        M_DELAYED: y = e;
        default: begin
          r = (k + lat > 255) ? 255 : k + lat;
          y = ((r / 16) == (r % 16));
        end
      endcase
      if (y != e) begin
        if (errs < 511) errs++;
        if (!fv) begin fv = 1'b1; fa = k / 16; fb = k % 16; end
      end
    end
  endfunction

  function automatic void build_exp(input int lat);
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < lat; k++) exp_q.push_back(8'd255);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input bit which, input logic v);
    if (which) start2 = v; else start0 = v;
  endtask

  // Pulse start, then observe once per cycle at the falling edge until a
  // few cycles after done. mid_at>0 re-pulses start on that busy cycle.
  task automatic run_sweep(input bit which, input int mode, input int mid_at,
                           output int busy_cnt, output int done_cnt,
                           output int err_first, output bit timed_out);
    int tail;
    bit seen_done;
    sel = which;
    if (which) mode2 = mode; else mode0 = mode;
    obs_q.delete();
    busy_cnt = 0; done_cnt = 0; err_first = -1; timed_out = 1'b1;
    tail = 0; seen_done = 1'b0;
    @(negedge clk); set_start(which, 1'b1);
    @(negedge clk); set_start(which, 1'b0);
    for (int c = 0; c < 700; c++) begin
      if (obs_busy) begin
        if (busy_cnt == 0) err_first = int'(obs_err);
        busy_cnt++;
        obs_q.push_back({obs_a, obs_b});
      end
      if (obs_done) begin done_cnt++; seen_done = 1'b1; end
      set_start(which, (mid_at > 0) && obs_busy && (busy_cnt == mid_at));
      if (seen_done) begin
        tail++;
        if (tail > 4) begin timed_out = 1'b0; break; end
      end
      @(negedge clk);
    end
    set_start(which, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst0_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    total++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, ffa0, ffb0} !== 31'd0) begin
      bad++;
      $display("FAIL reset_l0: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b ffa=%0d ffb=%0d, want all 0",
               a0, b0, busy0, done0, pass0, err0, fv0, ffa0, ffb0);
    end
    total++;
    if ({a2, b2, busy2, done2, pass2, err2, fv2, ffa2, ffb2} !== 31'd0) begin
      bad++;
      $display("FAIL reset_l2: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b ffa=%0d ffb=%0d, want all 0",
               a2, b2, busy2, done2, pass2, err2, fv2, ffa2, ffb2);
    end
  endtask

  task automatic test_sweeps();
    // scenario table: instance, model, latency, mid-sweep start (1 = random)
    bit which_t[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int mode_t[7]  = '{M_IDEAL, M_STUCK0, M_STUCK1, M_DELAYED, M_IDEAL, M_IDEAL, M_STUCK1};
    int lat_t[7]   = '{0, 0, 0, 2, 2, 0, 2};
    bit mid_t[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int busy_cnt, done_cnt, err_first, e_err, e_fa, e_fb, mid_at, diff_at;
    bit timed_out, e_fv;
    for (int s = 0; s < 7; s++) begin
      mid_at = mid_t[s] ? int'($urandom_range(5, 250)) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(which_t[s], mode_t[s], mid_at, busy_cnt, done_cnt, err_first, timed_out);
      ref_sweep(mode_t[s], lat_t[s], e_err, e_fv, e_fa, e_fb);
      build_exp(lat_t[s]);

      total++;
      if (timed_out) begin bad++; $display("FAIL sweep%0d_timeout: no done within budget", s); end
      total++;
      if (busy_cnt != 256 + lat_t[s]) begin
        bad++; $display("FAIL sweep%0d_busy_len: got %0d want %0d", s, busy_cnt, 256 + lat_t[s]);
      end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL sweep%0d_done_pulses: got %0d want 1", s, done_cnt); end
      total++;
      diff_at = -1;
      if (obs_q.size() != exp_q.size()) diff_at = 9999;
      else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i] && diff_at < 0) diff_at = i;
      if (diff_at >= 0) begin
        bad++;
        $display("FAIL sweep%0d_vectors: first difference at %0d (size got %0d want %0d)",
                 s, diff_at, obs_q.size(), exp_q.size());
      end
      total++;
      if (obs_err !== 9'(e_err)) begin bad++; $display("FAIL sweep%0d_err_count: got %0d want %0d", s, obs_err, e_err); end
      total++;
      if (obs_fv !== e_fv) begin bad++; $display("FAIL sweep%0d_fail_valid: got %b want %b", s, obs_fv, e_fv); end
      total++;
      if (obs_ffa !== 4'(e_fa) || obs_ffb !== 4'(e_fb)) begin
        bad++; $display("FAIL sweep%0d_first_fail: got %0d/%0d want %0d/%0d", s, obs_ffa, obs_ffb, e_fa, e_fb);
      end
      total++;
      if (obs_pass !== (e_err == 0)) begin bad++; $display("FAIL sweep%0d_pass: got %b want %b", s, obs_pass, e_err == 0); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit found;
    int dcnt, busy_cnt, done_cnt, err_first;
    bit timed_out;
    sel = 1'b0; mode0 = M_STUCK1; found = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (busy0 && {a0, b0} == 8'd100) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!found) begin bad++; $display("FAIL rst_mid_reach: vector 100 not seen"); end
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    total++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, ffa0, ffb0} !== 31'd0) begin
      bad++;
      $display("FAIL rst_mid_values: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b ffa=%0d ffb=%0d, want all 0",
               a0, b0, busy0, done0, pass0, err0, fv0, ffa0, ffb0);
    end
    dcnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (done0 || busy0) dcnt++;
      @(negedge clk);
    end
    total++;
    if (dcnt != 0) begin bad++; $display("FAIL rst_mid_quiet: busy/done seen %0d cycles, want 0", dcnt); end
    run_sweep(1'b0, M_IDEAL, 0, busy_cnt, done_cnt, err_first, timed_out);
    total++;
    if (timed_out || obs_q.size() == 0 || obs_q[0] !== 8'd0 || busy_cnt != 256 || !pass0) begin
      bad++;
      $display("FAIL rst_mid_restart: timeout=%b first=%0d busy=%0d pass=%b, want 0/0 256 1",
               timed_out, (obs_q.size() != 0) ? obs_q[0] : 8'hff, busy_cnt, pass0);
    end
  endtask

  task automatic test_back_to_back();
    int fail_mode, e_err, e_fa, e_fb, busy_cnt, done_cnt, err_first;
    bit e_fv, timed_out;
    fail_mode = ($urandom_range(0, 1) == 0) ? M_STUCK0 : M_STUCK1;
    ref_sweep(fail_mode, 0, e_err, e_fv, e_fa, e_fb);
    run_sweep(1'b0, fail_mode, 0, busy_cnt, done_cnt, err_first, timed_out);
    repeat ($urandom_range(3, 20)) @(negedge clk);
    total++;
    if (timed_out || err0 !== 9'(e_err) || pass0 !== 1'b0 || fv0 !== e_fv) begin
      bad++;
      $display("FAIL b2b_hold: timeout=%b err=%0d pass=%b fv=%b, want err=%0d pass=0 fv=%b",
               timed_out, err0, pass0, fv0, e_err, e_fv);
    end
    run_sweep(1'b0, M_IDEAL, 0, busy_cnt, done_cnt, err_first, timed_out);
    total++;
    if (err_first != 0) begin bad++; $display("FAIL b2b_clear: err at first busy cycle %0d want 0", err_first); end
    total++;
    if (timed_out || pass0 !== 1'b1 || err0 !== 9'd0 || fv0 !== 1'b0 || busy_cnt != 256 || done_cnt != 1) begin
      bad++;
      $display("FAIL b2b_ideal: timeout=%b pass=%b err=%0d fv=%b busy=%0d done=%0d, want 0 1 0 0 256 1",
               timed_out, pass0, err0, fv0, busy_cnt, done_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sweeps();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
